// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_mux
// Brief    : Six-digit multiplexed 7-segment scanner. It takes a per-frame input
//            snapshot and adds inter-digit blanking. Leading-zero blanking of
//            Hour_M is enabled by defining LEADING_ZERO_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_mux #(
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] Sec_L,
  input  logic [6:0] Sec_M,
  input  logic [6:0] Min_L,
  input  logic [6:0] Min_M,
  input  logic [6:0] Hour_L,
  input  logic [6:0] Hour_M,
  output logic [6:0] seg_out,
  output logic [5:0] dig_an,
  output logic       frame_start
);

  localparam int               CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] c_show_last = CNT_W'(REFRESH_DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       c_last_idx  = 3'd5;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    SNAP  = 2'd1,
    SHOW  = 2'd2,
    BLANK = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]       r_snap [6];
  logic [6:0]       r_seg, w_seg_nxt;
  logic [5:0]       r_an, w_an_nxt;
  logic             r_fs, w_fs_nxt;
  logic [6:0]       w_cur_code;
  logic             w_blank_digit;

  always_comb begin
    case (r_idx)
      3'd0:    w_cur_code = r_snap[0];
      3'd1:    w_cur_code = r_snap[1];
      3'd2:    w_cur_code = r_snap[2];
      3'd3:    w_cur_code = r_snap[3];
      3'd4:    w_cur_code = r_snap[4];
      3'd5:    w_cur_code = r_snap[5];
      default: w_cur_code = 7'h00;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_digit = (r_idx == c_last_idx) && (r_snap[5] == 7'h3F);
`else
  assign w_blank_digit = 1'b0;
`endif

  // Output flops capture the decode of the current state, so every digit
  // change goes through an all-off cycle owned by BLANK/SNAP/OFF.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_seg_nxt   = 7'h00;
    w_an_nxt    = 6'h3F;
    w_fs_nxt    = 1'b0;
    if (!en) begin
      w_state_nxt = OFF;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        OFF: w_state_nxt = SNAP;
        SNAP: begin
          w_fs_nxt    = 1'b1;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
          w_state_nxt = SHOW;
        end
        SHOW: begin
          if (!w_blank_digit) begin
            w_seg_nxt = w_cur_code;
            w_an_nxt  = ~(6'b000001 << r_idx);
          end
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == c_show_last) w_state_nxt = BLANK;
        end
        BLANK: begin
          if (r_cnt == c_slot_last) begin
            w_cnt_nxt = '0;
            if (r_idx == c_last_idx) begin
              w_idx_nxt   = 3'd0;
              w_state_nxt = SNAP;
            end else begin
              w_idx_nxt   = r_idx + 3'd1;
              w_state_nxt = SHOW;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= OFF;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_seg   <= 7'h00;
      r_an    <= 6'h3F;
      r_fs    <= 1'b0;
      for (int i = 0; i < 6; i++) r_snap[i] <= 7'h00;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_fs    <= w_fs_nxt;
      if (en && (r_state == SNAP)) begin
        r_snap[0] <= Sec_L;
        r_snap[1] <= Sec_M;
        r_snap[2] <= Min_L;
        r_snap[3] <= Min_M;
        r_snap[4] <= Hour_L;
        r_snap[5] <= Hour_M;
      end
    end
  end

  assign seg_out     = r_seg;
  assign dig_an      = r_an;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000: clock cycles per digit slot; legal range REFRESH_DIV > BLANK_CYC.
REQ-002 SHALL have parameter BLANK_CYC, default 4: all-off cycles at the end of each slot; legal range >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1: scan enable.
REQ-006 SHALL have ports Sec_L, Sec_M, Min_L, Min_M, Hour_L, Hour_M, each input, 7 bits: active-high segment codes, bit0 = a through bit6 = g, where 7'h3F is digit zero.
REQ-007 SHALL have port seg_out, output, 7 bits: active-high segment drive.
REQ-008 SHALL have port dig_an, output, 6 bits: active-low digit enables; bit0 = Sec_L through bit5 = Hour_M.
REQ-009 SHALL have port frame_start, output, 1: one-cycle pulse at each input snapshot.

Function
REQ-010 SHALL implement a state machine with states OFF, SNAP, SHOW and BLANK.
REQ-011 SHALL keep a digit index idx (0..5) and a slot counter cnt of width $clog2(REFRESH_DIV).
REQ-012 SNAP: SHALL load all six inputs into snapshot registers, pulse frame_start for exactly one cycle, set idx=0 and cnt=0, then go to SHOW.
REQ-013 SHOW: SHALL drive seg_out with snapshot[idx] and dig_an[idx]=0 with all other dig_an bits 1, for REFRESH_DIV-BLANK_CYC cycles, then go to BLANK.
REQ-014 BLANK: SHALL drive seg_out=0 and dig_an=6'h3F for BLANK_CYC cycles.
REQ-015 On BLANK exit with idx<5, SHALL set idx=idx+1, clear cnt, and go to SHOW.
REQ-016 On BLANK exit with idx=5, SHALL go to SNAP (idx wraps to 0); frame period is exactly 1+6*REFRESH_DIV cycles.
REQ-017 SHALL drive seg_out, dig_an and frame_start from flops only, with no combinational path from any input.
REQ-018 SHALL ignore input changes between snapshots; the display updates only at the next SNAP.
REQ-019 en low in any state SHALL force OFF on the next edge: seg_out=0, dig_an=6'h3F, frame_start=0, idx=0, cnt=0.
REQ-020 en high in OFF SHALL move to SNAP on the next edge.
REQ-021 SHALL never drive more than one dig_an bit low in any cycle, including across state transitions.
REQ-022 In SNAP and OFF, SHALL drive all digits off.

Reset
REQ-023 While rst=0, SHALL immediately set state=OFF, idx=0, cnt=0, snapshots=0, seg_out=0, dig_an=6'h3F, frame_start=0.
REQ-024 Reset asserted mid-slot SHALL abort the frame with no partial-digit glitch after reset assertion.
REQ-025 After rst release with en=1, SHALL take the first edge to SNAP, assert frame_start on the second edge, and light digit 0 on the third edge.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-027 With LEADING_ZERO_BLANK_EN defined: in SHOW with idx=5 and snapshot Hour_M==7'h3F, SHALL drive seg_out=0 and dig_an=6'h3F; slot timing SHALL be unchanged.
REQ-028 Without LEADING_ZERO_BLANK_EN: SHALL display Hour_M normally, including zero.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-029 Inputs set to codes 0x06,0x5B,0x4F,0x66,0x6D,0x7D with en=1 SHALL produce in each slot: 6 cycles with dig_an one-hot-low in order 0..5 and the matching seg_out, then 2 cycles all-off; frame_start SHALL recur every 49 cycles.
REQ-030 Sec_L changed from 0x06 to 0x07 during the idx=2 slot SHALL keep 0x06 shown for the rest of that frame and show 0x07 after the next frame_start.
REQ-031 en dropped during idx=3 SHOW SHALL give dig_an=6'h3F and seg_out=0 on the next edge; en raised again SHALL be followed by a SNAP and a restart at idx=0.
REQ-032 rst pulled low at cnt=3 of idx=4 SHALL give immediate all-off outputs and zeroed snapshots; after release, REQ-025 timing SHALL hold.
REQ-033 Hour_M=0x3F SHALL blank the idx=5 slot (all-off for 8 cycles) with LEADING_ZERO_BLANK_EN defined, and show 0x3F for 6 cycles without it.
REQ-034 Every test SHALL check each cycle that at most one dig_an bit is low.
